// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: PC generator, in-order tagged instruction queue, redirect flush.
// Optional FETCH_PERF_CNT_EN adds saturating stall_cnt / flush_cnt outputs.
module fetch_queue_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ins_valid,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  input  logic        ins_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [15:0] flush_cnt
`endif
);
  localparam int            AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            CW      = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic [31:0]   resp_pc_reg, resp_pc_next;
  logic [CW-1:0] count_reg, count_next;
  logic [CW-1:0] outstanding_reg, outstanding_next;
  logic [CW-1:0] discard_reg, discard_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [31:0]   entry_data [DEPTH];
  logic [31:0]   entry_pc   [DEPTH];

  logic [CW:0]   occupancy;
  logic          req_fire;
  logic          push;
  logic          pop;
  logic [31:0]   redirect_aligned;

  assign redirect_aligned = {redirect_pc[31:2], 2'b00};
  assign occupancy        = {1'b0, count_reg} + {1'b0, outstanding_reg};
  // Queued plus in-flight fetches never exceed DEPTH, so every kept response has a slot.
  assign imem_req  = rst_n && !redirect_valid && (occupancy < {1'b0, DEPTH_C});
  assign imem_addr = fetch_pc_reg;
  assign req_fire  = imem_req && imem_gnt;
  assign push      = imem_rvalid && (discard_reg == '0) && !redirect_valid;
  assign pop       = ins_valid && ins_ready && !redirect_valid;

  assign ins_valid = (count_reg != '0);
  assign ins       = entry_data[rd_ptr_reg];
  assign ins_pc    = entry_pc[rd_ptr_reg];

  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    resp_pc_next     = resp_pc_reg;
    count_next       = count_reg;
    wr_ptr_next      = wr_ptr_reg;
    rd_ptr_next      = rd_ptr_reg;
    discard_next     = discard_reg;
    outstanding_next = outstanding_reg + CW'(req_fire) - CW'(imem_rvalid);
    if (redirect_valid) begin
      fetch_pc_next = redirect_aligned;
      resp_pc_next  = redirect_aligned;
      count_next    = '0;
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
      // Everything still in flight after this edge belongs to the abandoned path,
      // including responses already marked stale by an earlier redirect.
      discard_next  = outstanding_next;
    end else begin
      if (req_fire)
        fetch_pc_next = fetch_pc_reg + 32'd4;
      if (push) begin
        resp_pc_next = resp_pc_reg + 32'd4;
        wr_ptr_next  = wr_ptr_reg + AW'(1);
      end
      if (pop)
        rd_ptr_next = rd_ptr_reg + AW'(1);
      count_next = count_reg + CW'(push) - CW'(pop);
      if (imem_rvalid && (discard_reg != '0))
        discard_next = discard_reg - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_reg    <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      count_reg       <= '0;
      outstanding_reg <= '0;
      discard_reg     <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      resp_pc_reg     <= resp_pc_next;
      count_reg       <= count_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [31:0] data_reg;
      logic [31:0] pc_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_reg <= '0;
          pc_reg   <= '0;
        end else if (push && (wr_ptr_reg == AW'(gi))) begin
          data_reg <= imem_rdata;
          pc_reg   <= resp_pc_reg;
        end
      end

      assign entry_data[gi] = data_reg;
      assign entry_pc[gi]   = pc_reg;
    end
  endgenerate

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (ins_ready && !ins_valid && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 32'd1;
      if (redirect_valid && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

  assert property (@(posedge clk) disable iff (!rst_n) !(imem_rvalid && (count_reg == DEPTH_C)));

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: random memory latency/grant/ready/redirect traffic
// against a program-order scoreboard, plus directed latency, backpressure, flush and wrap cases.
`timescale 1ns/1ps
module tb_fetch_queue_unit;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'd0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ins_valid;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic        ins_ready;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  fetch_queue_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ins_valid(ins_valid), .ins(ins), .ins_pc(ins_pc), .ins_ready(ins_ready)
`ifdef FETCH_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
  typedef struct { logic [31:0] addr; int due; } pend_t;

  exp_t        exp_q[$];   // program-order instructions decode is still owed
  pend_t       pend_q[$];  // memory model: granted, not yet answered
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] exp_next;
  int          gnt_pct = 100, ready_pct = 100, redir_pm = 0, lat = 1;
  logic        force_redir = 1'b0;
  logic [31:0] force_pc = '0;
  int          grants = 0;
  logic [31:0] last_grant = '0;
  int          stall_exp = 0, flush_exp = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Drive the inputs of the cycle that just began (called 1ns after posedge).
  task automatic drive();
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memf(pend_q[0].addr);
      void'(pend_q.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    imem_gnt  = (int'($urandom_range(99)) < gnt_pct);
    ins_ready = (int'($urandom_range(99)) < ready_pct);
    if (force_redir) begin
      redirect_valid = 1'b1;
      redirect_pc    = force_pc;
      force_redir    = 1'b0;
    end else if (int'($urandom_range(999)) < redir_pm) begin
      redirect_valid = 1'b1;
      if ($urandom_range(3) == 0) redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
      else                        redirect_pc = $urandom & 32'h0000_0FFF;
    end else begin
      redirect_valid = 1'b0;
      redirect_pc    = $urandom;
    end
  endtask

  // Mid-cycle view of what the coming edge will do: fetch stream and memory bookkeeping.
  task automatic capture();
    if (redirect_valid) begin
      chk("req_in_redirect", 32'(imem_req), 32'd0);
      exp_q.delete();
      exp_next = {redirect_pc[31:2], 2'b00};
      flush_exp++;
    end else if (imem_req && imem_gnt) begin
      chk("fetch_addr", imem_addr, exp_next);
      exp_q.push_back('{pc: exp_next, data: memf(exp_next)});
      pend_q.push_back('{addr: imem_addr, due: cyc + lat});
      exp_next   = exp_next + 32'd4;
      grants++;
      last_grant = imem_addr;
    end
    if (ins_ready && !ins_valid) stall_exp++;
  endtask

  task automatic step();
    @(negedge clk);
    if (rst_n) capture();
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; ins_ready = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_valid", 32'(ins_valid), 32'd0);
    chk("rst_ins", ins, 32'd0);
    chk("rst_ins_pc", ins_pc, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_stall_cnt", stall_cnt, 32'd0);
    chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete(); pend_q.delete();
    exp_next = RESET_PC; cyc = 0; grants = 0; stall_exp = 0; flush_exp = 0;
    force_redir = 1'b0;
    drive();
  endtask

  // Scoreboard monitor: whatever decode sees must be the oldest owed instruction.
  always @(negedge clk) begin
    if (rst_n && ins_valid && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ins: got pc %h ins %h, expected no valid instruction", ins_pc, ins);
      end else begin
        chk("ins_pc", ins_pc, exp_q[0].pc);
        chk("ins", ins, exp_q[0].data);
        if (ins_ready) begin
          $display("deliver pc=%h ins=%h", ins_pc, ins);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0;
    rst_n = 1'b0;

    // Streaming: grant always, latency 1, decode always ready.
    lat = 1; gnt_pct = 100; ready_pct = 100; redir_pm = 0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      #1;
      chk("p1_valid", 32'(ins_valid), (c >= 2) ? 32'd1 : 32'd0);
      if (c >= 2) chk("p1_pc", ins_pc, 32'(4 * (c - 2)));
      step();
    end

    // Backpressure: exactly DEPTH fetches then hold.
    ready_pct = 0;
    do_reset();
    repeat (10) step();
    #1;
    chk("p2_grants", 32'(grants), 32'(DEPTH));
    chk("p2_last_addr", last_grant, 32'd12);
    chk("p2_req_held", 32'(imem_req), 32'd0);
    chk("p2_head_pc", ins_pc, 32'd0);
    ready_pct = 100;
    repeat (12) step();
    #1;
    chk("p2_resumed", 32'(grants > DEPTH), 32'd1);

    // Redirect with three fetches in flight at latency 3.
    lat = 3; gnt_pct = 100; ready_pct = 100;
    do_reset();
    step(); step();
    force_redir = 1'b1; force_pc = 32'h0000_003B;
    step();
    #1;
    for (int i = 0; i < 30 && !ins_valid; i++) begin step(); #1; end
    chk("p3_found", 32'(ins_valid), 32'd1);
    chk("p3_first_pc", ins_pc, 32'h38);

    // Redirect and pop in the same cycle with two entries queued.
    lat = 1; gnt_pct = 100; ready_pct = 0;
    do_reset();
    step();
    gnt_pct = 0;
    step(); step(); step();
    #1;
    chk("p4_valid_before", 32'(ins_valid), 32'd1);
    ready_pct = 100; force_redir = 1'b1; force_pc = 32'h0000_0100;
    step();
    #1;
    chk("p4_valid_redir", 32'(ins_valid), 32'd1);
    gnt_pct = 100;
    step();
    #1;
    chk("p4_flushed", 32'(ins_valid), 32'd0);
    for (int i = 0; i < 20 && !ins_valid; i++) begin step(); #1; end
    chk("p4_first_pc", ins_pc, 32'h100);

    // Fetch PC wraps past the top of the address space.
    force_redir = 1'b1; force_pc = 32'hFFFF_FFFC;
    step(); step();
    g0 = grants;
    for (int i = 0; i < 20 && grants < g0 + 2; i++) step();
    chk("p5_wrap_addr", last_grant, 32'd0);

`ifdef FETCH_PERF_CNT_EN
    gnt_pct = 0; ready_pct = 100;
    do_reset();
    repeat (5) step();
    force_redir = 1'b1; force_pc = 32'h40; step();
    force_redir = 1'b1; force_pc = 32'h80; step();
    step();
    #1;
    chk("p6_flush_cnt", 32'(flush_cnt), 32'd2);
    chk("p6_stall_cnt", stall_cnt, 32'(stall_exp));
`endif

    // Randomised traffic, with one reset in the middle.
    do_reset();
    for (int seg = 0; seg < 40; seg++) begin
      lat       = int'($urandom_range(4, 1));
      gnt_pct   = int'($urandom_range(100, 30));
      ready_pct = int'($urandom_range(100, 20));
      redir_pm  = int'($urandom_range(40, 0));
      if (seg == 20) do_reset();
      repeat (50) step();
    end

    redir_pm = 0; gnt_pct = 0; ready_pct = 100;
    for (int i = 0; i < 100 && (exp_q.size() != 0 || pend_q.size() != 0); i++) step();
    step(); step();
    chk("drain_owed", 32'(exp_q.size()), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    #1;
    chk("end_flush_cnt", 32'(flush_cnt), 32'(flush_exp));
    chk("end_stall_cnt", stall_cnt, 32'(stall_exp));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
